// File: rtl/ofmap_writeback.sv
// ofmap_writeback: requantizes per-channel accumulator results and
// stores one output feature map per channel for synchronous readback.
module ofmap_writeback #(
    parameter  int dataSize      = 8,
    parameter  int numInChannel  = 1,
    parameter  int numOutChannel = 3,
    parameter  int numRegister   = 256,
    localparam int outputSize    = dataSize * 2 + $clog2(numInChannel) + 1,
    localparam int numAddrBuffer = $clog2(numRegister)
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         ctrl_start,
    input  logic [15:0]                  cfg_ofmap_width,
    input  logic [4:0]                   cfg_shift,
    input  logic                         cfg_relu,
    input  logic                         in_valid,
    input  logic signed [outputSize-1:0] in_data [numOutChannel],
    input  logic                         rd_en,
    input  logic [numAddrBuffer-1:0]     rd_addr,
    output logic signed [dataSize-1:0]   rd_data [numOutChannel],
    output logic                         flag_busy,
    output logic                         flag_done,
    output logic                         err_cfg,
    output logic [15:0]                  sat_count
);

    localparam int EW = outputSize + 1;
    localparam int WW = dataSize * numOutChannel;
    localparam logic signed [EW-1:0] QMAX = EW'((2 ** (dataSize - 1)) - 1);
    localparam logic signed [EW-1:0] QMIN = -QMAX - EW'(1);
    localparam logic [numAddrBuffer:0] DEPTH = (numAddrBuffer + 1)'(numRegister);
    localparam logic [31:0] NREG = 32'(numRegister);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [4:0]  shift_q;
    logic        relu_q;
    logic [31:0] total_q;
    logic [31:0] acc_cnt_q;
    logic [31:0] total_in;
    logic        start_go;
    logic        start_err;
    logic        accept;

    logic                     s1_valid_q;
    logic [WW-1:0]            s1_word_q;
    logic [numAddrBuffer-1:0] wr_ptr_q;
    logic [WW-1:0]            rd_word_q;
    logic [WW-1:0]            mem [numRegister];

    logic [WW-1:0]        q_word;
    logic [15:0]          sat_inc;
    logic [16:0]          sat_sum;
    logic signed [EW-1:0] bias;
    logic signed [EW-1:0] xe;
    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] r;
    logic                 big_shift;
    logic                 rd_ok;

    assign total_in  = 32'(cfg_ofmap_width) * 32'(cfg_ofmap_width);
    assign start_err = (cfg_ofmap_width != '0) && (total_in > NREG);
    assign big_shift = 32'(shift_q) >= 32'(outputSize);
    assign rd_ok     = {1'b0, rd_addr} < DEPTH;
    assign flag_busy = (state_q == RUN) || (state_q == DRAIN);
    assign flag_done = (state_q == DONE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (ctrl_start) begin
                    start_go = 1'b1;
                    if (cfg_ofmap_width == '0 || start_err) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (acc_cnt_q + 32'd1 == total_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!s1_valid_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Rounding shift at one extra bit so the bias add never overflows.
    always_comb begin
        q_word  = '0;
        sat_inc = '0;
        xe      = '0;
        sum     = '0;
        r       = '0;
        bias    = '0;
        if (shift_q != '0) begin
            bias = EW'(1) << (shift_q - 5'd1);
        end
        for (int c = 0; c < numOutChannel; c++) begin
            xe  = EW'(in_data[c]);
            sum = xe + bias;
            if (big_shift) begin
                r = xe[EW-1] ? '1 : '0;
            end else begin
                r = sum >>> shift_q;
            end
            if (relu_q && r[EW-1]) begin
                r = '0;
            end
            if (r > QMAX) begin
                r       = QMAX;
                sat_inc = sat_inc + 16'd1;
            end else if (r < QMIN) begin
                r       = QMIN;
                sat_inc = sat_inc + 16'd1;
            end
            q_word[c*dataSize +: dataSize] = r[dataSize-1:0];
        end
    end

    assign sat_sum = {1'b0, sat_count} + {1'b0, sat_inc};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shift_q    <= '0;
            relu_q     <= 1'b0;
            total_q    <= '0;
            acc_cnt_q  <= '0;
            err_cfg    <= 1'b0;
            sat_count  <= '0;
            s1_valid_q <= 1'b0;
            s1_word_q  <= '0;
            wr_ptr_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (start_go) begin
                shift_q   <= cfg_shift;
                relu_q    <= cfg_relu;
                total_q   <= total_in;
                acc_cnt_q <= '0;
                err_cfg   <= start_err;
                sat_count <= '0;
                wr_ptr_q  <= '0;
            end else begin
                if (accept) begin
                    acc_cnt_q <= acc_cnt_q + 32'd1;
                    s1_word_q <= q_word;
                    sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
                end
                if (s1_valid_q) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            mem[wr_ptr_q] <= s1_word_q;
        end
    end

    // Read-before-write: a colliding read sees the previous contents.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_word_q <= '0;
        end else if (rd_en) begin
            rd_word_q <= rd_ok ? mem[rd_addr] : '0;
        end
    end

    always_comb begin
        for (int c = 0; c < numOutChannel; c++) begin
            rd_data[c] = rd_word_q[c*dataSize +: dataSize];
        end
    end

endmodule

// File: tb/tb_ofmap_writeback.sv
// tb_ofmap_writeback: directed and randomized frames checked against a
// behavioural requantize/buffer model.
module tb_ofmap_writeback;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              ctrl_start = 1'b0;
    logic [15:0]       cfg_ofmap_width = '0;
    logic [4:0]        cfg_shift = '0;
    logic              cfg_relu = 1'b0;
    logic              in_valid = 1'b0;
    logic signed [16:0] in_data [3];
    logic              rd_en = 1'b0;
    logic [7:0]        rd_addr = '0;
    logic signed [7:0] rd_data [3];
    logic              flag_busy;
    logic              flag_done;
    logic              err_cfg;
    logic [15:0]       sat_count;

    ofmap_writeback dut (
        .clk             (clk),
        .nrst            (nrst),
        .ctrl_start      (ctrl_start),
        .cfg_ofmap_width (cfg_ofmap_width),
        .cfg_shift       (cfg_shift),
        .cfg_relu        (cfg_relu),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .flag_busy       (flag_busy),
        .flag_done       (flag_done),
        .err_cfg         (err_cfg),
        .sat_count       (sat_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pix [300][3];
    int mem_m [256][3];
    int m_total = 0;
    int m_cnt = 0;
    int m_shift = 0;
    bit m_relu = 1'b0;
    bit m_run = 1'b0;
    int sat_m = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int floordiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int rq(input int x, input int sh, input bit relu,
                              output bit sat);
        int v;
        if (sh >= 17) v = (x < 0) ? -1 : 0;
        else v = floordiv(x + ((sh > 0) ? (1 << (sh - 1)) : 0), 1 << sh);
        if (relu && v < 0) v = 0;
        sat = 1'b0;
        if (v > 127) begin v = 127; sat = 1'b1; end
        if (v < -128) begin v = -128; sat = 1'b1; end
        return v;
    endfunction

    task automatic start(input int w, input int sh, input bit relu);
        ctrl_start = 1'b1;
        cfg_ofmap_width = 16'(w);
        cfg_shift = 5'(sh);
        cfg_relu = relu;
        if (!m_run) begin
            m_total = w * w;
            m_cnt = 0;
            m_shift = sh;
            m_relu = relu;
            sat_m = 0;
            m_run = (w != 0) && (m_total <= 256);
        end
        tick();
        ctrl_start = 1'b0;
    endtask

    task automatic feed(input int i);
        bit s;
        for (int c = 0; c < 3; c++) in_data[c] = 17'(pix[i][c]);
        in_valid = 1'b1;
        if (m_run) begin
            for (int c = 0; c < 3; c++) begin
                mem_m[m_cnt][c] = rq(pix[i][c], m_shift, m_relu, s);
                if (s && sat_m < 65535) sat_m++;
            end
            m_cnt++;
            if (m_cnt == m_total) m_run = 1'b0;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 20 && !flag_done; k++) tick();
        check(tag, 32'(flag_done), 1);
    endtask

    task automatic read_chk(input int a, input string tag);
        rd_en = 1'b1;
        rd_addr = 8'(a);
        tick();
        rd_en = 1'b0;
        for (int c = 0; c < 3; c++)
            check($sformatf("%s[%0d].%0d", tag, a, c), rd_data[c], mem_m[a][c]);
    endtask

    function automatic int rnd_acc();
        return int'($urandom_range(0, 131071)) - 65536;
    endfunction

    task automatic rand_frame(input int w, input string tag);
        start(w, int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < w * w; i++) begin
            for (int c = 0; c < 3; c++) pix[i][c] = rnd_acc();
            feed(i);
        end
        wait_done({tag, "_done"});
        check({tag, "_sat"}, 32'(sat_count), sat_m);
        for (int a = 0; a < w * w; a++) read_chk(a, tag);
    endtask

    int old [3];

    initial begin
        for (int c = 0; c < 3; c++) in_data[c] = '0;

        // 1: reset, basic frame, done timing
        tick();
        tick();
        check("rst_busy", 32'(flag_busy), 0);
        check("rst_done", 32'(flag_done), 0);
        check("rst_err", 32'(err_cfg), 0);
        check("rst_sat", 32'(sat_count), 0);
        check("rst_rd0", rd_data[0], 0);
        nrst = 1'b1;
        tick();
        start(3, 0, 1'b0);
        check("t1_busy", 32'(flag_busy), 1);
        for (int p = 1; p <= 9; p++) begin
            pix[p-1][0] = p;
            pix[p-1][1] = -p;
            pix[p-1][2] = 2 * p;
            feed(p - 1);
        end
        check("t1_done_t0", 32'(flag_done), 0);
        tick();
        check("t1_done_t1", 32'(flag_done), 0);
        check("t1_busy_t1", 32'(flag_busy), 1);
        tick();
        check("t1_done_t2", 32'(flag_done), 1);
        check("t1_busy_t2", 32'(flag_busy), 0);
        for (int a = 0; a < 9; a++) read_chk(a, "t1");
        check("t1_p9c2", rd_data[2], 18);
        check("t1_sat", 32'(sat_count), 0);

        // 2: saturation
        start(1, 0, 1'b0);
        pix[0][0] = 300; pix[0][1] = -300; pix[0][2] = 5;
        feed(0);
        wait_done("t2_done");
        read_chk(0, "t2");
        check("t2_hi", rd_data[0], 127);
        check("t2_lo", rd_data[1], -128);
        check("t2_sat", 32'(sat_count), 2);

        // 3: rounding with and without relu
        start(1, 4, 1'b0);
        pix[0][0] = 40; pix[0][1] = -40; pix[0][2] = 24;
        feed(0);
        wait_done("t3_done");
        read_chk(0, "t3");
        check("t3_neg", rd_data[1], -2);
        start(1, 4, 1'b1);
        feed(0);
        wait_done("t3r_done");
        read_chk(0, "t3r");
        check("t3r_neg", rd_data[1], 0);

        // 4: config errors
        start(17, 0, 1'b0);
        check("t4_err", 32'(err_cfg), 1);
        check("t4_done", 32'(flag_done), 1);
        check("t4_busy", 32'(flag_busy), 0);
        read_chk(0, "t4_keep");
        start(0, 0, 1'b0);
        check("t4z_done", 32'(flag_done), 1);
        check("t4z_err", 32'(err_cfg), 0);

        // 5: protocol: gaps, collision read, mid-run start, extras
        rand_frame(4, "t5pre");
        start(3, 1, 1'b0);
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < 3; c++) begin
                pix[k][c] = rnd_acc();
                old[c] = mem_m[k][c];
            end
            feed(k);
            rd_en = 1'b1;
            rd_addr = 8'(k);
            tick();
            rd_en = 1'b0;
            for (int c = 0; c < 3; c++)
                check($sformatf("t5_coll[%0d].%0d", k, c), rd_data[c], old[c]);
            if (k == 4) start(5, 3, 1'b1);
            else if (k != 8) tick();
        end
        for (int k = 9; k < 12; k++) begin
            for (int c = 0; c < 3; c++) pix[k][c] = rnd_acc();
            feed(k);
        end
        wait_done("t5_done");
        check("t5_sat", 32'(sat_count), sat_m);
        for (int a = 0; a < 12; a++) read_chk(a, "t5");

        // boundary total == depth, then random widths
        rand_frame(16, "full");
        rand_frame(int'($urandom_range(1, 15)), "rnd1");
        rand_frame(int'($urandom_range(1, 15)), "rnd2");

        // 6: async reset mid-run
        start(3, 2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 3; c++) pix[i][c] = rnd_acc();
            feed(i);
        end
        #2;
        nrst = 1'b0;
        #1;
        check("t6_busy", 32'(flag_busy), 0);
        check("t6_done", 32'(flag_done), 0);
        check("t6_err", 32'(err_cfg), 0);
        check("t6_sat", 32'(sat_count), 0);
        check("t6_rd", rd_data[0], 0);
        m_run = 1'b0;
        #3;
        nrst = 1'b1;
        tick();
        check("t6_idle_done", 32'(flag_done), 0);
        rand_frame(2, "t6new");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ofmap_writeback.md
Name: ofmap_writeback

Overview:
Downstream stage of tpu_system. Consumes the per-output-channel accumulator results (matrix_out) of the 9x3 weight-stationary array. Requantizes each value to dataSize bits (rounding shift, optional ReLU, saturation) and stores one output feature map per channel in an internal buffer. The buffer has a synchronous read port; flag_done asserts when the whole ofmap is stored.

Parameters:
dataSize, 8, activation/output element width
numInChannel, 1, input channels; sets accumulator width
numOutChannel, 3, output channels (nPEx)
numRegister, 256, output buffer depth per channel
outputSize, dataSize*2+$clog2(numInChannel)+1 (17), accumulator input width, derived localparam
numAddrBuffer, $clog2(numRegister), buffer address width, derived localparam

Ports:
clk  in  1  clock, all logic on rising edge
nrst  in  1  asynchronous active-low reset
ctrl_start  in  1  one-cycle pulse; latch config and begin a frame
cfg_ofmap_width  in  16  ofmap side length (ifmap_width-kernelWidth+1); frame is width^2 pixels
cfg_shift  in  5  right-shift amount for requantization
cfg_relu  in  1  1 = clamp negatives to 0
in_valid  in  1  in_data holds one output pixel, all channels aligned
in_data  in  signed outputSize x numOutChannel  accumulator values (unpacked array [numOutChannel])
rd_en  in  1  buffer read enable
rd_addr  in  numAddrBuffer  pixel address (row*width+col)
rd_data  out  dataSize x numOutChannel  signed requantized values, 1-cycle read latency
flag_busy  out  1  high in RUN/DRAIN
flag_done  out  1  high in DONE, held until next ctrl_start
err_cfg  out  1  width^2 > numRegister at start; held until next ctrl_start
sat_count  out  16  count of saturated elements this frame, sticky at 0xFFFF

Behaviour:
- Reset (async, nrst=0): state IDLE, flag_busy=0, flag_done=0, err_cfg=0, sat_count=0, rd_data=0, wr_ptr=0, pipeline valids=0. Buffer contents are not reset.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + ctrl_start: latch cfg_*, compute total = width^2 (32-bit), clear wr_ptr/accepted count/sat_count, clear flag_done/err_cfg.
  - If width==0, next state is DONE.
  - Else if total > numRegister, next state is DONE and err_cfg=1; no writes.
  - Else next state is RUN.
- ctrl_start during RUN/DRAIN is ignored.
- RUN: each in_valid is accepted; increment accepted count. When the accepted count reaches total, go to DRAIN. in_valid beyond total is ignored.
- in_valid in IDLE/DRAIN/DONE is ignored.
- DRAIN: wait until the pipeline is empty, then go to DONE (two cycles after the last accepted pixel).
- Pipeline stage 1 (registered), per channel:
  - r = (x + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, computed at outputSize+1 bits. Arithmetic shift, round half toward +inf.
  - If relu and r<0, r=0.
  - Saturate to [-2^(dataSize-1), 2^(dataSize-1)-1]. Each clamped element adds 1 to sat_count, saturating at 0xFFFF.
  - shift >= outputSize yields 0 or -1 by sign.
- Pipeline stage 2: write all channels at wr_ptr, then increment wr_ptr.
- Latency: in_valid at edge t; data readable via rd_en issued at edge t+2 or later, with rd_data valid after the following edge.
- Read: synchronous, rd_data updates only when rd_en=1, otherwise holds. Allowed in any state.
  - Same-cycle read/write to the same address returns the old data.
  - rd_addr >= numRegister returns 0.
- Reset mid-frame returns to IDLE immediately. Partial buffer contents remain but are undefined to software.

Test Plan:
1. Reset -> all outputs 0, state IDLE. Start with width=3, shift=0, relu=0 -> flag_busy=1 next cycle. Feed 9 pixels {p,-p,2p}, p=1..9 -> flag_done two cycles after the 9th. Read addr 0..8 -> {p,-p,2p}, sat_count=0.
2. Saturation: shift=0, in_data {300,-300,5} -> stored {127,-128,5}, sat_count=2.
3. Rounding: shift=4, in_data {40,-40,24} -> {3,-2,2}. Same with relu=1 -> {3,0,2}.
4. Config errors: width=17 (289>256) start -> err_cfg=1 and flag_done=1 next cycle, buffer unchanged. width=0 -> flag_done=1, err_cfg=0.
5. Protocol: in_valid gapped (1 on / 2 off), 3 extra pixels after total, ctrl_start mid-RUN -> exactly 9 writes, extras and start ignored, second frame after DONE overwrites from addr 0.
6. Async reset asserted mid-RUN between clock edges -> outputs 0 immediately. New start then completes normally.
